mem_listing_loader: RTL
=======================

# mem_listing_loader

Byte-stream program loader that writes {address, data} listing records into CPU memory before execution begins. It sits between a host/testbench byte source and the shared memory write port. It holds the 6502 core in `cpu_hold` while loading, then releases it with the start PC taken from the end record. It is the writer for the same listing images that instruction fetch later reads.

## Interface
- `ADDR_W`, 16, memory address width.
- `DATA_W`, 8, memory data width and stream byte width.

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle pulse that begins a load session; ignored while `busy`
- `in_valid`  in  1  stream byte valid
- `in_data`  in  8  stream byte
- `in_ready`  out  1  loader can accept a byte this cycle
- `mem_addr`  out  ADDR_W  write/read address
- `mem_wdata`  out  DATA_W  write data
- `mem_we`  out  1  write request, held until `mem_ack`
- `mem_re`  out  1  readback request; constant 0 unless `LOADER_READBACK_EN`
- `mem_rdata`  in  DATA_W  readback data, valid on the `mem_ack` cycle
- `mem_ack`  in  1  memory completes the current request
- `cpu_hold`  out  1  keeps the CPU stalled
- `busy`  out  1  session in progress
- `done`  out  1  one-cycle pulse when a session ends
- `err`  out  1  sticky error flag; cleared by `start` or `rst`
- `start_pc`  out  16  PC from the end record
- `rec_count`  out  16  data records written this session; saturates at 0xFFFF

## Operation
- Record format: tag byte, then payload.
  - Tag 0x01 = data record: addr_hi, addr_lo, data.
  - Tag 0x00 = end record: pc_hi, pc_lo.
  - Any other tag is illegal.
- States and transitions:
  - IDLE: `start` → TAG; also clears `err` and `rec_count`.
  - TAG: on accept, 0x01 → AHI; 0x00 → PHI; other → set `err`, go to FIN.
  - AHI → ALO → DAT: each advances on byte accept.
  - DAT: on accept, latch data, go to WR.
  - WR: `mem_we`=1 with a stable `mem_addr`/`mem_wdata`. On `mem_ack`, increment `rec_count` and go to RB (if readback is compiled in) or TAG.
  - RB: `mem_re`=1 at the same address. On `mem_ack`, compare `mem_rdata` with the latched data; a mismatch sets `err`. Then go to TAG.
  - PHI → PLO: on accept, load `start_pc`, go to FIN.
  - FIN: pulse `done` for one cycle, go to IDLE.
- `in_ready`=1 only in TAG, AHI, ALO, DAT, PHI and PLO. A byte transfers when `in_valid && in_ready`.
- `busy`=1 and `cpu_hold`=1 in every state except IDLE.
- `err` does not abort a readback mismatch session; it aborts only on an illegal tag.
- Addresses are used as given; there is no auto-increment and no wrap logic. Address 0xFFFF is legal.

## Timing
- Reset values:
  - `in_ready`, `mem_we`, `mem_re`, `busy`, `done`, `err` = 0.
  - `cpu_hold` = 1. The CPU stays stalled after reset until the first session completes.
  - `mem_addr`, `mem_wdata`, `start_pc`, `rec_count` = 0.
  - State = IDLE.
- `cpu_hold` release:
  - After the first `done`, `cpu_hold` = 0 in IDLE.
  - It reasserts on the cycle after a new `start`.
- `mem_we` and `mem_re` are registered. The request rises the cycle after state entry.
- `mem_ack` in the same cycle the request is asserted is accepted. The request drops the next cycle.
- A `mem_ack` while no request is asserted is ignored.
- Minimum data record cost: 4 accept cycles + 1 request cycle + 1 ack cycle. Readback adds 2 cycles.
- `start` during `busy` has no effect.
- `rst` mid-session:
  - Returns to IDLE immediately and drops `mem_we`/`mem_re` on the next edge.
  - A partially written record is discarded.
  - `cpu_hold` returns to 1.
- `in_valid` with `in_ready`=0 is not consumed; the source must hold the byte.
- `done` and `err` can be asserted in the same cycle when FIN is entered via an illegal tag.

## Configuration
- `LOADER_READBACK_EN` defined:
  - RB state is present and each write is verified by a read.
  - A mismatch sets `err`.
- Not defined:
  - RB is removed and `mem_re` is tied to 0.
  - `mem_rdata` is unused.
  - WR goes directly to TAG on ack.

## Test plan
- Reset then idle → `cpu_hold`=1, `busy`=0, `in_ready`=0; holding `in_valid`=1 consumes nothing.
- `start`, stream 01 01 00 A0, 01 01 01 00, 00 01 00 → writes 0xA0@0x0100 then 0x00@0x0101. Required: `rec_count`=2, `start_pc`=0x0100, one `done` pulse, `err`=0, `cpu_hold`=0 afterwards.
- Memory model delays `mem_ack` by 5 cycles on the write to 0x001E (data 0xAA) → `mem_we` and `mem_addr` stay stable for all 5 cycles; `in_ready`=0 throughout.
- Illegal tag 0x7F after `start` → `err`=1, `done` pulses, `rec_count`=0, no memory request issued.
- With `LOADER_READBACK_EN`: write 0xBB@0x001F while the model returns 0xBA → `err`=1 and the session continues to the end record. A following `start` clears `err`.
- `rst` asserted in WR while awaiting ack → next cycle `mem_we`=0, state IDLE, `cpu_hold`=1, `rec_count`=0.

Source files
------------

// File: rtl/mem_listing_loader.sv
// Byte-stream listing loader: writes {address, data} records into memory and holds the CPU
// until the end record supplies the start PC. Define LOADER_READBACK_EN to verify each write by a read.
module mem_listing_loader #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       start_pc,
    output logic [15:0]       rec_count
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_TAG  = 4'd1;
    localparam logic [3:0] S_AHI  = 4'd2;
    localparam logic [3:0] S_ALO  = 4'd3;
    localparam logic [3:0] S_DAT  = 4'd4;
    localparam logic [3:0] S_WR   = 4'd5;
    localparam logic [3:0] S_PHI  = 4'd6;
    localparam logic [3:0] S_PLO  = 4'd7;
    localparam logic [3:0] S_FIN  = 4'd8;
`ifdef LOADER_READBACK_EN
    localparam logic [3:0] S_RB   = 4'd9;
`endif

    logic [3:0]        state;
    logic [DATA_W-1:0] hi_byte;
    logic              accept;

    // Handshakes: a stream byte transfers on a rising edge with in_valid && in_ready, and the
    // source holds in_data until then. mem_we/mem_re stay high until the edge that sees mem_ack.
    assign in_ready = (state == S_TAG) || (state == S_AHI) || (state == S_ALO) ||
                      (state == S_DAT) || (state == S_PHI) || (state == S_PLO);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_FIN);

`ifndef LOADER_READBACK_EN
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
    assign mem_re       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            hi_byte   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
`ifdef LOADER_READBACK_EN
            mem_re    <= 1'b0;
`endif
            cpu_hold  <= 1'b1;
            err       <= 1'b0;
            start_pc  <= '0;
            rec_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_TAG;
                        err       <= 1'b0;
                        rec_count <= '0;
                        cpu_hold  <= 1'b1;
                    end
                end
                S_TAG: begin
                    if (accept) begin
                        if (in_data == DATA_W'(1)) begin
                            state <= S_AHI;
                        end else if (in_data == '0) begin
                            state <= S_PHI;
                        end else begin
                            err   <= 1'b1;
                            state <= S_FIN;
                        end
                    end
                end
                S_AHI: begin
                    if (accept) begin
                        hi_byte <= in_data;
                        state   <= S_ALO;
                    end
                end
                S_ALO: begin
                    if (accept) begin
                        mem_addr <= ADDR_W'({hi_byte, in_data});
                        state    <= S_DAT;
                    end
                end
                S_DAT: begin
                    if (accept) begin
                        mem_wdata <= in_data;
                        state     <= S_WR;
                    end
                end
                // The request register rises one cycle after entry; an ack counts only while it is high.
                S_WR: begin
                    if (mem_we && mem_ack) begin
                        mem_we <= 1'b0;
                        if (rec_count != 16'hFFFF) begin
                            rec_count <= rec_count + 16'd1;
                        end
`ifdef LOADER_READBACK_EN
                        state <= S_RB;
`else
                        state <= S_TAG;
`endif
                    end else begin
                        mem_we <= 1'b1;
                    end
                end
`ifdef LOADER_READBACK_EN
                S_RB: begin
                    if (mem_re && mem_ack) begin
                        mem_re <= 1'b0;
                        if (mem_rdata != mem_wdata) begin
                            err <= 1'b1;
                        end
                        state <= S_TAG;
                    end else begin
                        mem_re <= 1'b1;
                    end
                end
`endif
                S_PHI: begin
                    if (accept) begin
                        hi_byte <= in_data;
                        state   <= S_PLO;
                    end
                end
                S_PLO: begin
                    if (accept) begin
                        start_pc <= 16'({hi_byte, in_data});
                        state    <= S_FIN;
                    end
                end
                S_FIN: begin
                    cpu_hold <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
